pulse_stretcher: RTL and testbench

//  Converts single-cycle request pulses (e.g. from edge_to_pulse) back into wide, well-separated output pulses.

---
 rtl/pulse_stretcher_channel.sv | 105 ++++++++++
 rtl/pulse_stretcher.sv | 42 ++++
 tb/tb_pulse_stretcher.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_stretcher_channel.sv
// One channel: queues single-cycle requests and replays each as a PULSE_CLOCKS-wide pulse.
// Consecutive pulses are separated by exactly GAP_CLOCKS low cycles.
module pulse_stretcher_channel #(
  parameter int PULSE_CLOCKS = 8,
  parameter int GAP_CLOCKS   = 4,
  parameter int PENDING_BITS = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in,
  input  logic                    clear_overflow,
  output logic                    out,
  output logic                    toggle,
  output logic                    busy,
  output logic                    overflow,
  output logic [PENDING_BITS-1:0] pending
);

  localparam int MAX_CLOCKS = (PULSE_CLOCKS > GAP_CLOCKS) ? PULSE_CLOCKS : GAP_CLOCKS;
  localparam int CW         = $clog2(MAX_CLOCKS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [CW-1:0]           HIGH_LOAD = CW'(PULSE_CLOCKS - 1);
  localparam logic [CW-1:0]           GAP_LOAD  = CW'(GAP_CLOCKS - 1);
  localparam logic [PENDING_BITS-1:0] PEND_MAX  = {PENDING_BITS{1'b1}};

  logic [1:0]              r_state;
  logic [CW-1:0]           r_cnt;
  logic                    w_opp;
  logic                    w_deq;
  logic                    w_start;
  logic                    w_enq;
  logic                    w_drop;
  logic [PENDING_BITS-1:0] w_pending_nxt;

  // A request arriving at the last gap cycle with nothing queued starts directly,
  // so back-to-back pulses keep exactly GAP_CLOCKS of low time and IDLE never holds work.
  always_comb begin
    w_opp         = (r_state == IDLE) || ((r_state == GAP) && (r_cnt == '0));
    w_deq         = w_opp && (pending != '0);
    w_start       = w_opp && ((pending != '0) || in);
    w_enq         = in && !(w_opp && (pending == '0));
    w_drop        = w_enq && !w_deq && (pending == PEND_MAX);
    w_pending_nxt = pending;
    if (w_enq && !w_deq && !w_drop) begin
      w_pending_nxt = pending + PENDING_BITS'(1);
    end else if (w_deq && !w_enq) begin
      w_pending_nxt = pending - PENDING_BITS'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      out      <= 1'b0;
      toggle   <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      pending  <= '0;
    end else begin
      pending <= w_pending_nxt;
      if (w_drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
      busy <= 1'b1;
      if (w_start) begin
        r_state <= HIGH;
        r_cnt   <= HIGH_LOAD;
        out     <= 1'b1;
        toggle  <= ~toggle;
      end else begin
        case (r_state)
          HIGH: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - CW'(1);
            end else begin
              r_state <= GAP;
              r_cnt   <= GAP_LOAD;
              out     <= 1'b0;
            end
          end
          GAP: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - CW'(1);
            end else begin
              r_state <= IDLE;
              busy    <= (w_pending_nxt != '0);
            end
          end
          default: begin
            r_state <= IDLE;
            busy    <= (w_pending_nxt != '0);
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/pulse_stretcher.sv
// WIDTH independent pulse stretcher channels sharing clock and reset only.
// Pending counts are flattened channel-major into one bus.
module pulse_stretcher #(
  parameter int WIDTH        = 1,
  parameter int PULSE_CLOCKS = 8,
  parameter int GAP_CLOCKS   = 4,
  parameter int PENDING_BITS = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [WIDTH-1:0]              in,
  input  logic [WIDTH-1:0]              clear_overflow,
  output logic [WIDTH-1:0]              out,
  output logic [WIDTH-1:0]              toggle,
  output logic [WIDTH-1:0]              busy,
  output logic [WIDTH-1:0]              overflow,
  output logic [WIDTH*PENDING_BITS-1:0] pending
);

  if (PULSE_CLOCKS < 1 || GAP_CLOCKS < 1 || PENDING_BITS < 1) begin : g_param_check
    $error("pulse_stretcher: PULSE_CLOCKS, GAP_CLOCKS and PENDING_BITS must all be >= 1");
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    pulse_stretcher_channel #(
      .PULSE_CLOCKS (PULSE_CLOCKS),
      .GAP_CLOCKS   (GAP_CLOCKS),
      .PENDING_BITS (PENDING_BITS)
    ) u_ch (
      .clock          (clock),
      .reset_n        (reset_n),
      .in             (in[gi]),
      .clear_overflow (clear_overflow[gi]),
      .out            (out[gi]),
      .toggle         (toggle[gi]),
      .busy           (busy[gi]),
      .overflow       (overflow[gi]),
      .pending        (pending[gi*PENDING_BITS +: PENDING_BITS])
    );
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed spot-check table for the documented scenarios, plus a randomized run,
// with every cycle compared against a timestamp-based reference model.
module tb_pulse_stretcher;

  localparam int W    = 2;
  localparam int P    = 8;
  localparam int G    = 4;
  localparam int PB   = 2;
  localparam int QMAX = (1 << PB) - 1;

  localparam int S_OUT  = 0;
  localparam int S_TOG  = 1;
  localparam int S_BUSY = 2;
  localparam int S_OVF  = 3;
  localparam int S_PEND = 4;

  logic            clock;
  logic            reset_n;
  logic [W-1:0]    in_s;
  logic [W-1:0]    clr_s;
  logic [W-1:0]    out;
  logic [W-1:0]    toggle;
  logic [W-1:0]    busy;
  logic [W-1:0]    overflow;
  logic [W*PB-1:0] pending;

  pulse_stretcher #(
    .WIDTH        (W),
    .PULSE_CLOCKS (P),
    .GAP_CLOCKS   (G),
    .PENDING_BITS (PB)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in             (in_s),
    .clear_overflow (clr_s),
    .out            (out),
    .toggle         (toggle),
    .busy           (busy),
    .overflow       (overflow),
    .pending        (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int t;
    int cyc;
    int ch;
    int sig;
    int val;
  } chk_t;

  chk_t chks[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Model: pulse start edge, earliest next start edge, queued count.
  int m_s[W];
  int m_ns[W];
  int m_q[W];
  bit m_tog[W];
  bit m_ovf[W];

  task automatic model_edge(input logic [W-1:0] iv, input logic [W-1:0] cv, input logic rv);
    bit opp;
    bit drop;
    for (int c = 0; c < W; c++) begin
      if (!rv) begin
        m_s[c] = -1000; m_ns[c] = 0; m_q[c] = 0; m_tog[c] = 0; m_ovf[c] = 0;
      end else begin
        opp  = (cyc >= m_ns[c]);
        drop = 0;
        if (opp && (m_q[c] > 0 || iv[c])) begin
          if (m_q[c] > 0 && !iv[c]) m_q[c] = m_q[c] - 1;
          m_s[c]   = cyc;
          m_ns[c]  = cyc + P + G;
          m_tog[c] = ~m_tog[c];
        end else if (iv[c]) begin
          if (m_q[c] == QMAX) drop = 1;
          else m_q[c] = m_q[c] + 1;
        end
        if (drop) m_ovf[c] = 1;
        else if (cv[c]) m_ovf[c] = 0;
      end
    end
  endtask

  function automatic logic [W*(4+PB)-1:0] model_vec();
    logic [W-1:0]    e_out, e_tog, e_busy, e_ovf;
    logic [W*PB-1:0] e_pend;
    for (int c = 0; c < W; c++) begin
      e_out[c]           = (cyc >= m_s[c]) && (cyc < m_s[c] + P);
      e_tog[c]           = m_tog[c];
      e_busy[c]          = (cyc < m_ns[c]) || (m_q[c] != 0);
      e_ovf[c]           = m_ovf[c];
      e_pend[c*PB +: PB] = PB'(m_q[c]);
    end
    return {e_out, e_tog, e_busy, e_ovf, e_pend};
  endfunction

  task automatic tick(input logic [W-1:0] iv, input logic [W-1:0] cv, input logic rv);
    logic [W*(4+PB)-1:0] got;
    logic [W*(4+PB)-1:0] exp;
    in_s    = iv;
    clr_s   = cv;
    reset_n = rv;
    @(posedge clock);
    #1;
    model_edge(iv, cv, rv);
    exp = model_vec();
    got = {out, toggle, busy, overflow, pending};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL model edge %0d: got %h exp %h (out,tog,busy,ovf,pend)", cyc, got, exp);
    end
    cyc++;
  endtask

  function automatic int dut_sig(input int ch, input int sig);
    case (sig)
      S_OUT:   return int'(out[ch]);
      S_TOG:   return int'(toggle[ch]);
      S_BUSY:  return int'(busy[ch]);
      S_OVF:   return int'(overflow[ch]);
      default: return int'(pending[ch*PB +: PB]);
    endcase
  endfunction

  function automatic void stim(input int t, input int e, output logic [W-1:0] iv,
                               output logic [W-1:0] cv, output logic rv);
    iv = '0;
    cv = '0;
    rv = (e >= 2);
    case (t)
      1: if (e == 10) iv[0] = 1'b1;
      2: if (e >= 10 && e <= 12) iv[0] = 1'b1;
      3: begin
        if (e >= 10 && e <= 14) iv[0] = 1'b1;
        if (e == 60) cv[0] = 1'b1;
      end
      4: if (e == 10 || e == 11 || e == 22) iv[0] = 1'b1;
      5: begin
        if (e == 10 || e == 11) iv[0] = 1'b1;
        if (e == 14) rv = 1'b0;
      end
      default: begin
        if (e >= 10 && e <= 14) iv[0] = 1'b1;
        if (e == 13) iv[1] = 1'b1;
      end
    endcase
  endfunction

  task automatic add(input int t, input int c, input int ch, input int sig, input int val);
    chk_t k;
    k.t = t; k.cyc = c; k.ch = ch; k.sig = sig; k.val = val;
    chks.push_back(k);
  endtask

  initial begin
    logic [W-1:0] iv, cv;
    logic         rv;
    string        names[5];
    names[0] = "out"; names[1] = "toggle"; names[2] = "busy";
    names[3] = "overflow"; names[4] = "pending";
    in_s = '0; clr_s = '0; reset_n = 1'b0;

    // Spot checks: cycle c means the value seen after the edge that sampled cycle c-1's inputs.
    add(1, 2, 0, S_OUT, 0);   add(1, 2, 0, S_BUSY, 0);  add(1, 2, 0, S_PEND, 0);
    add(1, 11, 0, S_OUT, 1);  add(1, 18, 0, S_OUT, 1);  add(1, 19, 0, S_OUT, 0);
    add(1, 11, 0, S_TOG, 1);  add(1, 30, 0, S_TOG, 1);  add(1, 11, 0, S_BUSY, 1);
    add(1, 22, 0, S_BUSY, 1); add(1, 23, 0, S_BUSY, 0); add(1, 15, 0, S_PEND, 0);
    add(2, 13, 0, S_PEND, 2); add(2, 11, 0, S_OUT, 1);  add(2, 19, 0, S_OUT, 0);
    add(2, 22, 0, S_OUT, 0);  add(2, 23, 0, S_OUT, 1);  add(2, 35, 0, S_OUT, 1);
    add(2, 42, 0, S_OUT, 1);  add(2, 43, 0, S_OUT, 0);  add(2, 46, 0, S_BUSY, 1);
    add(2, 47, 0, S_BUSY, 0); add(2, 24, 0, S_TOG, 0);  add(2, 50, 0, S_TOG, 1);
    add(3, 14, 0, S_PEND, 3); add(3, 14, 0, S_OVF, 0);  add(3, 15, 0, S_OVF, 1);
    add(3, 47, 0, S_OUT, 1);  add(3, 54, 0, S_OUT, 1);  add(3, 55, 0, S_OUT, 0);
    add(3, 59, 0, S_OUT, 0);  add(3, 66, 0, S_OUT, 0);  add(3, 47, 0, S_PEND, 0);
    add(3, 60, 0, S_OVF, 1);  add(3, 61, 0, S_OVF, 0);  add(3, 48, 0, S_TOG, 0);
    add(4, 12, 0, S_PEND, 1); add(4, 22, 0, S_PEND, 1); add(4, 23, 0, S_PEND, 1);
    add(4, 23, 0, S_OUT, 1);  add(4, 35, 0, S_OUT, 1);  add(4, 35, 0, S_PEND, 0);
    add(4, 47, 0, S_OUT, 0);
    add(5, 14, 0, S_OUT, 1);  add(5, 14, 0, S_PEND, 1); add(5, 15, 0, S_OUT, 0);
    add(5, 15, 0, S_PEND, 0); add(5, 15, 0, S_TOG, 0);  add(5, 15, 0, S_BUSY, 0);
    add(5, 23, 0, S_OUT, 0);  add(5, 30, 0, S_BUSY, 0);
    add(6, 11, 0, S_OUT, 1);  add(6, 18, 0, S_OUT, 1);  add(6, 19, 0, S_OUT, 0);
    add(6, 13, 1, S_OUT, 0);  add(6, 14, 1, S_OUT, 1);  add(6, 21, 1, S_OUT, 1);
    add(6, 22, 1, S_OUT, 0);  add(6, 15, 0, S_OVF, 1);  add(6, 20, 1, S_OVF, 0);
    add(6, 14, 1, S_TOG, 1);  add(6, 20, 1, S_PEND, 0);

    for (int t = 1; t <= 6; t++) begin
      for (int e = 0; e < 70; e++) begin
        stim(t, e, iv, cv, rv);
        tick(iv, cv, rv);
        foreach (chks[k]) begin
          if (chks[k].t == t && chks[k].cyc == e + 1) begin
            n_tests++;
            if (dut_sig(chks[k].ch, chks[k].sig) != chks[k].val) begin
              n_fail++;
              $display("FAIL test%0d cycle %0d ch%0d %s: got %0d exp %0d", t, e + 1,
                       chks[k].ch, names[chks[k].sig], dut_sig(chks[k].ch, chks[k].sig),
                       chks[k].val);
            end
          end
        end
      end
    end

    // Random traffic dense enough to saturate the queue and race gap boundaries.
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < W; c++) begin
        iv[c] = ($urandom_range(0, 2) == 0);
        cv[c] = ($urandom_range(0, 15) == 0);
      end
      rv = (n < 2) ? 1'b0 : ($urandom_range(0, 299) != 0);
      tick(iv, cv, rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
